// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display controller: FSM states,
// special segment patterns, value limit and the double-dabble adjust step.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [7:0]  SEG_BLANK  = 8'hFF;
    localparam logic [7:0]  SEG_DASH   = 8'hBF;
    localparam logic [15:0] MAX_VALUE  = 16'd9999;
    localparam int          NUM_DIGITS = 4;

    // Add 3 to every BCD nibble that is 5 or more, so that the following
    // left shift carries correctly into the next decimal digit.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
        logic [15:0] r;
        r = bcd;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                r[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/encoder.sv
// Combinational BCD/hex digit to active-low 7-segment pattern.
// Ports:
//   digit_i  4-bit digit
//   seg_o    8-bit pattern, bit 7 = DP (always 1, off), bits 6..0 = g..a
module encoder (
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);

    always_comb begin
        unique case (digit_i)
            4'h0: seg_o = 8'hC0;
            4'h1: seg_o = 8'hF9;
            4'h2: seg_o = 8'hA4;
            4'h3: seg_o = 8'hB0;
            4'h4: seg_o = 8'h99;
            4'h5: seg_o = 8'h92;
            4'h6: seg_o = 8'h82;
            4'h7: seg_o = 8'hF8;
            4'h8: seg_o = 8'h80;
            4'h9: seg_o = 8'h90;
            4'hA: seg_o = 8'h88;
            4'hB: seg_o = 8'h83;
            4'hC: seg_o = 8'hC6;
            4'hD: seg_o = 8'hA1;
            4'hE: seg_o = 8'h86;
            default: seg_o = 8'h8E;
        endcase
    end

endmodule

// File: rtl/display_ctrl.sv
// Sequencing controller for four 7-segment displays. A binary value is taken
// through a load/busy handshake, converted to BCD by a 16-step double-dabble
// engine, then the four display registers are written one per cycle through a
// single shared encoder.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load, value     request to display value (sampled only when not busy)
//   busy            conversion/write in progress
//   done            one-cycle pulse after hex3 has been written
//   hex0..hex3      active-low segment patterns, hex0 = least significant
module display_ctrl
    import display_pkg::*;
#(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [7:0]  hex0,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [1:0]  idx_q;
    logic [15:0] bin_q;
    logic [15:0] bcd_q;
    logic        ovf_q;
    logic [7:0]  hex_q [NUM_DIGITS];

    logic        accept;
    logic [15:0] bcd_adj;
    logic [3:0]  enc_digit;
    logic [7:0]  enc_seg;
    logic [7:0]  seg_d;
    logic        upper_zero;

    // The done cycle behaves like IDLE for the handshake, so a load there is
    // taken without losing a cycle.
    assign accept  = load && (state_q == IDLE || state_q == DONE);
    assign bcd_adj = bcd_adjust(bcd_q);

    assign enc_digit = bcd_q[{idx_q, 2'b00} +: 4];

    encoder u_encoder (
        .digit_i (enc_digit),
        .seg_o   (enc_seg)
    );

    // Nibbles idx..3 all zero means this digit is a leading zero.
    assign upper_zero = ((bcd_q >> {idx_q, 2'b00}) == 16'd0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        seg_d   = enc_seg;

        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (BLANK_LEADING && idx_q != 2'd0 && upper_zero) begin
            seg_d = SEG_BLANK;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = (value > MAX_VALUE) ? WRITE : CONVERT;
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: if (cnt_q == 4'd15) state_d = WRITE;
            WRITE:   if (idx_q == 2'(NUM_DIGITS - 1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            // NOTE: the display registers are reset explicitly because reset
            // must blank the visible digits, not just the control state.
            for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        bin_q <= value;
                        bcd_q <= '0;
                        ovf_q <= (value > MAX_VALUE);
                        cnt_q <= '0;
                        idx_q <= '0;
                    end
                end
                CONVERT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt_q          <= cnt_q + 4'd1;
                end
                WRITE: begin
                    hex_q[idx_q] <= seg_d;
                    idx_q        <= idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == CONVERT) || (state_q == WRITE);
    assign done = (state_q == DONE);
    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];

endmodule
